// File: rtl/ui_controller.sv
`default_nettype none
// ============================================================================
// Module   : ui_controller
// Purpose  : Front-panel controller for the digital clock. Synchronises and
//            debounces five push-buttons, generates increment pulses with
//            hold-to-repeat, steps mode/select, toggles the alarm and timer
//            enables, and runs the ring FSM (IDLE/RING/MUTED) that drives a
//            beeping tone on the speaker with acknowledge and timeout.
// Ports    : clk_i, reset_i (async, active-high)
//            btn_{c,u,l,r,d}_i   raw buttons, active-high, asynchronous
//            alarm_out_i, timer_out_i  ring request levels from clock core
//            mode_o[1:0]   0 CLOCK, 1 TIMER, 2 ALARM
//            select_o[1:0] 0 NONE, 1 SEC, 2 MIN, 3 HOUR
//            increment_o   one-cycle pulse
//            alarm_enable_o, timer_enable_o  levels
//            aud_pwm_o     speaker drive
//            ringing_o     high while the ring FSM is in RING
// Revision : 1.0 - initial release
// ============================================================================
module ui_controller #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100,
  parameter int TONE_HZ         = 1500,
  parameter int BEEP_MS         = 250,
  parameter int RING_TIMEOUT_S  = 60
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_c_i,
  input  logic       btn_u_i,
  input  logic       btn_l_i,
  input  logic       btn_r_i,
  input  logic       btn_d_i,
  input  logic       alarm_out_i,
  input  logic       timer_out_i,
  output logic [1:0] mode_o,
  output logic [1:0] select_o,
  output logic       increment_o,
  output logic       alarm_enable_o,
  output logic       timer_enable_o,
  output logic       aud_pwm_o,
  output logic       ringing_o
);

  // Derived cycle counts
  localparam int     c_deb_cyc   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int     c_rdly_cyc  = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
  localparam int     c_rep_cyc   = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int     c_half_cyc  = CLK_FREQ / (2 * TONE_HZ);
  localparam int     c_beep_cyc  = CLK_FREQ / 1000 * BEEP_MS;
  // Ring timeout overflows 32 bits for realistic clocks, so compute it wide
  localparam longint c_ring_cyc  = longint'(CLK_FREQ) * longint'(RING_TIMEOUT_S);
  localparam int     c_rep_max   = (c_rdly_cyc > c_rep_cyc) ? c_rdly_cyc : c_rep_cyc;

  localparam int c_deb_w  = $clog2(c_deb_cyc) + 1;
  localparam int c_rep_w  = $clog2(c_rep_max) + 1;
  localparam int c_half_w = $clog2(c_half_cyc) + 1;
  localparam int c_beep_w = $clog2(c_beep_cyc) + 1;
  localparam int c_ring_w = $clog2(c_ring_cyc) + 1;

  localparam logic [c_deb_w-1:0]  c_deb_term  = c_deb_w'(c_deb_cyc);
  localparam logic [c_rep_w-1:0]  c_rdly_term = c_rep_w'(c_rdly_cyc);
  localparam logic [c_rep_w-1:0]  c_rep_term  = c_rep_w'(c_rep_cyc);
  localparam logic [c_half_w-1:0] c_half_last = c_half_w'(c_half_cyc - 1);
  localparam logic [c_beep_w-1:0] c_beep_last = c_beep_w'(c_beep_cyc - 1);
  localparam logic [c_ring_w-1:0] c_ring_last = c_ring_w'(c_ring_cyc - 1);

  // Button indices into the raw/press vectors
  localparam int c_btn_c = 0;
  localparam int c_btn_u = 1;
  localparam int c_btn_l = 2;
  localparam int c_btn_r = 3;
  localparam int c_btn_d = 4;

  localparam logic [1:0] c_mode_clock = 2'd0;
  localparam logic [1:0] c_mode_timer = 2'd1;
  localparam logic [1:0] c_mode_alarm = 2'd2;
  localparam logic [1:0] c_sel_none   = 2'd0;
  localparam logic [1:0] c_sel_sec    = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RING  = 2'd1,
    ST_MUTED = 2'd2
  } ring_state_e;

  logic [4:0] w_btn_raw;
  logic [4:0] w_press;
  logic       w_db_u;

  assign w_btn_raw = {btn_d_i, btn_r_i, btn_l_i, btn_u_i, btn_c_i};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debounce and rising-edge press pulse
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    logic               sync1_q;
    logic               sync2_q;
    logic               db_q;
    logic               db_prev_q;
    logic [c_deb_w-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= w_btn_raw[gi];
        sync2_q   <= sync1_q;
        db_prev_q <= db_q;
        // Count only while the synchronised level disagrees with the
        // debounced level; any agreement restarts the stability window.
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_deb_term) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_press[gi] = db_q & ~db_prev_q;

    if (gi == c_btn_u) begin : g_u_level
      assign w_db_u = db_q;
    end
  end

  // --------------------------------------------------------------------------
  // Hold-to-repeat for btn_u. rep_cnt_q equals the number of cycles since
  // the press pulse (or since the last repeat pulse).
  // --------------------------------------------------------------------------
  logic [c_rep_w-1:0] rep_cnt_q;
  logic               rep_first_q;
  logic [c_rep_w-1:0] w_rep_tgt;
  logic               w_rep_pulse;

  assign w_rep_tgt   = rep_first_q ? c_rdly_term : c_rep_term;
  assign w_rep_pulse = w_db_u & ~w_press[c_btn_u] & (rep_cnt_q == w_rep_tgt);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else if (w_press[c_btn_u]) begin
      rep_cnt_q   <= c_rep_w'(1);
      rep_first_q <= 1'b1;
    end else if (!w_db_u) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (w_rep_pulse) begin
      rep_cnt_q   <= c_rep_w'(1);
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Ring FSM, user controls and audio
  // --------------------------------------------------------------------------
  ring_state_e         state_q;
  logic [1:0]          mode_q;
  logic [1:0]          select_q;
  logic                inc_q;
  logic                alarm_en_q;
  logic                timer_en_q;
  logic                aud_q;
  logic                ringing_q;
  logic                alarm_q;
  logic                timer_q;
  logic                cause_timer_q;
  logic                tone_q;
  logic                beep_q;
  logic [c_half_w-1:0] tone_cnt_q;
  logic [c_beep_w-1:0] beep_cnt_q;
  logic [c_ring_w-1:0] to_cnt_q;

  logic       w_rise_a;
  logic       w_rise_t;
  logic       w_req_low;
  logic       w_tone_wrap;
  logic       w_beep_wrap;
  logic       w_tone_d;
  logic       w_beep_d;
  logic [1:0] w_mode_usr;
  logic [1:0] w_select_usr;
  logic       w_ten_usr;

  assign w_rise_a    = alarm_out_i & ~alarm_q;
  assign w_rise_t    = timer_out_i & ~timer_q;
  assign w_req_low   = ~alarm_out_i & ~timer_out_i;
  assign w_tone_wrap = (tone_cnt_q == c_half_last);
  assign w_beep_wrap = (beep_cnt_q == c_beep_last);
  // Next tone/beep values feed the audio register so the speaker follows the
  // toggles without an extra cycle of lag.
  assign w_tone_d    = w_tone_wrap ? ~tone_q : tone_q;
  assign w_beep_d    = w_beep_wrap ? ~beep_q : beep_q;

  // Button effects outside RING; btn_r overrides btn_d on the same cycle.
  always_comb begin
    w_mode_usr   = mode_q;
    w_select_usr = select_q;
    w_ten_usr    = timer_en_q;
    if (w_press[c_btn_c] && (mode_q == c_mode_timer)) begin
      w_ten_usr = ~timer_en_q;
    end
    if (w_press[c_btn_r]) begin
      case (mode_q)
        c_mode_clock: begin
          w_mode_usr   = c_mode_timer;
          w_select_usr = c_sel_sec;
        end
        c_mode_timer: begin
          w_mode_usr   = c_mode_alarm;
          w_select_usr = c_sel_sec;
        end
        default: begin
          w_mode_usr   = c_mode_clock;
          w_select_usr = c_sel_none;
        end
      endcase
    end else if (w_press[c_btn_d]) begin
      w_select_usr = select_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      mode_q        <= c_mode_clock;
      select_q      <= c_sel_none;
      inc_q         <= 1'b0;
      alarm_en_q    <= 1'b0;
      timer_en_q    <= 1'b0;
      aud_q         <= 1'b0;
      ringing_q     <= 1'b0;
      alarm_q       <= 1'b0;
      timer_q       <= 1'b0;
      cause_timer_q <= 1'b0;
      tone_q        <= 1'b0;
      beep_q        <= 1'b0;
      tone_cnt_q    <= '0;
      beep_cnt_q    <= '0;
      to_cnt_q      <= '0;
    end else begin
      alarm_q <= alarm_out_i;
      timer_q <= timer_out_i;
      inc_q   <= (w_press[c_btn_u] | w_rep_pulse) &
                 (select_q != c_sel_none) & (state_q != ST_RING);
      aud_q   <= 1'b0;
      if (w_press[c_btn_l]) begin
        alarm_en_q <= ~alarm_en_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_rise_a || w_rise_t) begin
            state_q       <= ST_RING;
            ringing_q     <= 1'b1;
            mode_q        <= alarm_out_i ? c_mode_alarm : c_mode_timer;
            select_q      <= c_sel_none;
            cause_timer_q <= w_rise_t;
            tone_q        <= 1'b0;
            beep_q        <= 1'b1;
            tone_cnt_q    <= '0;
            beep_cnt_q    <= '0;
            to_cnt_q      <= '0;
          end else begin
            mode_q     <= w_mode_usr;
            select_q   <= w_select_usr;
            timer_en_q <= w_ten_usr;
          end
        end

        ST_RING: begin
          if (w_press[c_btn_c] || (to_cnt_q == c_ring_last)) begin
            state_q   <= ST_MUTED;
            ringing_q <= 1'b0;
            if (cause_timer_q) begin
              timer_en_q <= 1'b0;
            end
          end else if (w_req_low) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
          end else begin
            to_cnt_q   <= to_cnt_q + 1'b1;
            tone_cnt_q <= w_tone_wrap ? '0 : tone_cnt_q + 1'b1;
            beep_cnt_q <= w_beep_wrap ? '0 : beep_cnt_q + 1'b1;
            tone_q     <= w_tone_d;
            beep_q     <= w_beep_d;
            aud_q      <= w_tone_d & w_beep_d;
          end
        end

        ST_MUTED: begin
          // A request still held high must not re-ring; wait for it to drop.
          if (w_req_low) begin
            state_q <= ST_IDLE;
          end
          mode_q     <= w_mode_usr;
          select_q   <= w_select_usr;
          timer_en_q <= w_ten_usr;
        end

        default: begin
          state_q   <= ST_IDLE;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  assign mode_o         = mode_q;
  assign select_o       = select_q;
  assign increment_o    = inc_q;
  assign alarm_enable_o = alarm_en_q;
  assign timer_enable_o = timer_en_q;
  assign aud_pwm_o      = aud_q;
  assign ringing_o      = ringing_q;

endmodule
`default_nettype wire
